// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

    // Encoding of the instruction that ends a program.
    localparam logic [8:0] HALT_OP_DEFAULT = 9'h1FF;

    // Sequencer phases.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // Next-PC selection.
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with hold / increment / branch-target selection.
module pc_unit
    import seq_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;

    // Next-PC mux; the increment wraps naturally at the register width.
    always_comb begin
        pc_next = pc_reg;
        case (sel)
            PC_INC:    pc_next = pc_reg + 1'b1;
            PC_TARGET: pc_next = target;
            default:   pc_next = pc_reg;
        endcase
    end

    // PC register; clear (restart) takes priority over the mux.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else if (clear) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch / execute / memory sequencer for the 9-bit core.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int         PC_W    = 10,
    parameter logic [8:0] HALT_OP = HALT_OP_DEFAULT,
    parameter int         CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [8:0]       Instr,
    input  logic             Branch,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    input  logic             MemAck,
    output logic [PC_W-1:0]  PC,
    output logic             FetchEn,
    output logic             RegWriteEn,
    output logic             MemReq,
    output logic             MemWe,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    pc_sel_t          pc_sel;
    logic             restart;
    logic             retire;
    logic             latch_mem;
    logic             mem_we_reg;
    logic             is_load_reg;
    logic [CNT_W-1:0] count_reg;

    pc_unit #(
        .PC_W (PC_W)
    ) u_pc (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clear  (restart),
        .sel    (pc_sel),
        .target (Target),
        .pc     (PC)
    );

    // Next-state, PC selection and write-strobe gating.
    always_comb begin
        state_next = state_reg;
        pc_sel     = PC_HOLD;
        restart    = 1'b0;
        retire     = 1'b0;
        latch_mem  = 1'b0;
        RegWriteEn = 1'b0;
        case (state_reg)
            IDLE, HALT: begin
                if (Start) begin
                    restart    = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = EXEC;
            end
            EXEC: begin
                if (Instr == HALT_OP) begin
                    state_next = HALT;
                end else if (MemWrite || MemtoReg) begin
                    // Memory path wins even if a taken branch is flagged.
                    latch_mem  = 1'b1;
                    state_next = MEM;
                end else begin
                    RegWriteEn = RegWrite;
                    pc_sel     = (Branch && Taken) ? PC_TARGET : PC_INC;
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            MEM: begin
                if (MemAck) begin
                    RegWriteEn = is_load_reg;
                    pc_sel     = PC_INC;
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the memory-access kind on entry to MEM so it stays stable while waiting.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mem_we_reg  <= 1'b0;
            is_load_reg <= 1'b0;
        end else if (latch_mem) begin
            mem_we_reg  <= MemWrite;
            is_load_reg <= MemtoReg;
        end
    end

    // Retired-instruction counter, cleared on restart and saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= '0;
        end else if (retire && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign FetchEn    = (state_reg == FETCH);
    assign MemReq     = (state_reg == MEM);
    assign MemWe      = (state_reg == MEM) && mem_we_reg;
    assign Done       = (state_reg == HALT);
    assign InstrCount = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a table-driven ROM/decoder model.
module tb_instr_sequencer;

    typedef struct packed {
        logic [8:0] ins;
        logic       br;
        logic       tk;
        logic       rw;
        logic       mw;
        logic       mr;
        logic [9:0] tgt;
    } rom_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [8:0]  Instr;
    logic        Branch;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemtoReg;
    logic        Taken;
    logic [9:0]  Target;
    logic        MemAck;
    logic [9:0]  PC;
    logic        FetchEn;
    logic        RegWriteEn;
    logic        MemReq;
    logic        MemWe;
    logic        Done;
    logic [15:0] InstrCount;

    rom_t rom [1024];
    rom_t cur;

    int n_err = 0;
    int n_chk = 0;
    int fetch_q[$];
    int rwe_n;
    int rwe_first;
    int rwe_last;
    int done_cyc;

    always #5 Clk = ~Clk;

    instr_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Instr      (Instr),
        .Branch     (Branch),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .Taken      (Taken),
        .Target     (Target),
        .MemAck     (MemAck),
        .PC         (PC),
        .FetchEn    (FetchEn),
        .RegWriteEn (RegWriteEn),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .Done       (Done),
        .InstrCount (InstrCount)
    );

    // ROM with registered read; decoder and flag outputs come from the same entry.
    always @(posedge Clk) begin
        if (FetchEn) cur <= rom[PC];
    end

    assign Instr    = cur.ins;
    assign Branch   = cur.br;
    assign Taken    = cur.tk;
    assign RegWrite = cur.rw;
    assign MemWrite = cur.mw;
    assign MemtoReg = cur.mr;
    assign Target   = cur.tgt;

    function automatic rom_t mk(input logic [8:0] ins, input logic br, input logic tk,
                                input logic rw, input logic mw, input logic mr,
                                input logic [9:0] tgt);
        rom_t e;
        e.ins = ins; e.br = br; e.tk = tk; e.rw = rw; e.mw = mw; e.mr = mr; e.tgt = tgt;
        return e;
    endfunction

    task automatic fill_mov();
        for (int i = 0; i < 1024; i++) rom[i] = mk(9'h001, 0, 0, 1, 0, 0, 10'd0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a program (edge 0 = the Start edge) and run until Done or budget.
    task automatic run_prog(input string tag, input int budget);
        fetch_q.delete();
        rwe_n = 0; rwe_first = -1; rwe_last = -1; done_cyc = -1;
        Start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (c == 0) begin
                Start = 1'b0;
                chk({tag, "_start_done_clr"}, Done, 1'b0);
                chk({tag, "_start_pc0"}, PC, 10'd0);
                chk({tag, "_start_cnt0"}, InstrCount, 16'd0);
            end
            if (FetchEn) fetch_q.push_back(int'(PC));
            if (RegWriteEn) begin
                if (rwe_first < 0) rwe_first = c;
                rwe_last = c;
                rwe_n++;
            end
            if (Done) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, "_reached_done"}, Done, 1'b1);
    endtask

    task automatic wait_memreq(input string tag);
        for (int c = 0; c < 40; c++) begin
            if (MemReq) break;
            tick();
        end
        chk({tag, "_memreq_seen"}, MemReq, 1'b1);
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        MemAck  = 1'b0;
        fill_mov();

        // Reset held two cycles, then idle with Start low.
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_pc", PC, 10'd0);
        chk("rst_done", Done, 1'b0);
        chk("rst_fetchen", FetchEn, 1'b0);
        chk("rst_rwe", RegWriteEn, 1'b0);
        chk("rst_memreq", MemReq, 1'b0);
        chk("rst_memwe", MemWe, 1'b0);
        chk("rst_cnt", InstrCount, 16'd0);

        // Three MOVs then HALT.
        rom[3] = mk(9'h1FF, 0, 0, 0, 0, 0, 10'd0);
        run_prog("mov3", 30);
        chk("mov3_rwe_pulses", rwe_n, 3);
        chk("mov3_rwe_first", rwe_first, 1);
        chk("mov3_rwe_last", rwe_last, 5);
        chk("mov3_done_cycle", done_cyc, 8);
        chk("mov3_count", InstrCount, 16'd3);
        chk("mov3_pc_held", PC, 10'd3);
        tick();
        tick();
        chk("mov3_done_held", Done, 1'b1);
        chk("mov3_count_held", InstrCount, 16'd3);

        // Taken branch at PC 2 to 7 (restarted from HALT).
        fill_mov();
        rom[2] = mk(9'h087, 1, 1, 0, 0, 0, 10'd7);
        rom[7] = mk(9'h1FF, 0, 0, 0, 0, 0, 10'd0);
        run_prog("br_tk", 40);
        chk("br_tk_nfetch", fetch_q.size(), 4);
        if (fetch_q.size() == 4) chk("br_tk_pc_after", fetch_q[3], 7);
        chk("br_tk_count", InstrCount, 16'd3);
        chk("br_tk_rwe", rwe_n, 2);

        // Identical re-execution after Start in HALT.
        run_prog("br_tk2", 40);
        chk("br_tk2_nfetch", fetch_q.size(), 4);
        if (fetch_q.size() == 4) chk("br_tk2_pc_after", fetch_q[3], 7);
        chk("br_tk2_count", InstrCount, 16'd3);
        chk("br_tk2_done_cycle", done_cyc, 8);

        // Same branch not taken falls through to 3.
        rom[2] = mk(9'h087, 1, 0, 0, 0, 0, 10'd7);
        run_prog("br_nt", 60);
        chk("br_nt_nfetch", fetch_q.size(), 8);
        if (fetch_q.size() == 8) chk("br_nt_pc_after", fetch_q[3], 3);
        chk("br_nt_count", InstrCount, 16'd7);

        // Load at PC 4, MemAck on the third MEM cycle.
        fill_mov();
        rom[4] = mk(9'h050, 0, 0, 1, 0, 1, 10'd0);
        rom[5] = mk(9'h1FF, 0, 0, 0, 0, 0, 10'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_memreq("ld");
        chk("ld_pc", PC, 10'd4);
        chk("ld_memwe", MemWe, 1'b0);
        chk("ld_rwe_wait1", RegWriteEn, 1'b0);
        tick();
        chk("ld_memreq2", MemReq, 1'b1);
        chk("ld_rwe_wait2", RegWriteEn, 1'b0);
        tick();
        chk("ld_memreq3", MemReq, 1'b1);
        MemAck = 1'b1;
        #1;
        chk("ld_rwe_ack", RegWriteEn, 1'b1);
        tick();
        MemAck = 1'b0;
        chk("ld_memreq_drop", MemReq, 1'b0);
        chk("ld_fetch_next", FetchEn, 1'b1);
        chk("ld_pc_next", PC, 10'd5);
        chk("ld_count", InstrCount, 16'd5);
        tick();
        tick();
        chk("ld_halt", Done, 1'b1);

        // Store at PC 4 also flagged as a taken branch: memory path wins.
        rom[4] = mk(9'h0C9, 1, 1, 0, 1, 0, 10'd9);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_memreq("st");
        chk("st_memwe", MemWe, 1'b1);
        chk("st_rwe_wait", RegWriteEn, 1'b0);
        MemAck = 1'b1;
        #1;
        chk("st_rwe_ack", RegWriteEn, 1'b0);
        tick();
        MemAck = 1'b0;
        chk("st_pc_next", PC, 10'd5);
        chk("st_memreq_drop", MemReq, 1'b0);
        chk("st_memwe_drop", MemWe, 1'b0);

        // PC wraps from all-ones to 0.
        tick();
        tick();
        fill_mov();
        rom[0] = mk(9'h0BF, 1, 1, 0, 0, 0, 10'h3FF);
        fetch_q.delete();
        Start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) Start = 1'b0;
            if (FetchEn) fetch_q.push_back(int'(PC));
        end
        chk("wrap_nfetch", fetch_q.size(), 3);
        if (fetch_q.size() == 3) begin
            chk("wrap_pc_max", fetch_q[1], 1023);
            chk("wrap_pc_zero", fetch_q[2], 0);
        end
        chk("wrap_count", InstrCount, 16'd2);

        // Reset during MEM; a late MemAck has no effect.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        rom[0] = mk(9'h050, 0, 0, 1, 0, 1, 10'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_memreq("rmem");
        Reset_n = 1'b0;
        MemAck = 1'b1;
        tick();
        chk("rmem_memreq", MemReq, 1'b0);
        chk("rmem_memwe", MemWe, 1'b0);
        chk("rmem_pc", PC, 10'd0);
        Reset_n = 1'b1;
        tick();
        tick();
        chk("rmem_late_memreq", MemReq, 1'b0);
        chk("rmem_late_fetch", FetchEn, 1'b0);
        chk("rmem_late_rwe", RegWriteEn, 1'b0);
        chk("rmem_late_cnt", InstrCount, 16'd0);
        chk("rmem_late_pc", PC, 10'd0);
        chk("rmem_late_done", Done, 1'b0);
        MemAck = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
